// File: rtl/write_back_pkg.sv
// write_back_pkg: write-back source codes and request bundle shared by the arbiter and its users.
package write_back_pkg;
  typedef enum logic [1:0] {
    WRITE_BACK_SEL_ALU  = 2'd0,
    WRITE_BACK_SEL_MEM  = 2'd1,
    WRITE_BACK_SEL_PC   = 2'd2,
    WRITE_BACK_SEL_RSVD = 2'd3
  } write_back_select_t;
  localparam int WB_NUM_SRC = 3;
  localparam int WB_STARVE_LIMIT_DEFAULT = 4;
  localparam int WB_XLEN = 32;
  localparam int WB_REG_ADDR_W = 5;
  typedef struct packed {
    logic                     valid;
    logic [WB_REG_ADDR_W-1:0] rd;
    logic [WB_XLEN-1:0]       data;
  } wb_req_t;
endpackage

// File: rtl/wb_wait_counter.sv
// wb_wait_counter: counts consecutive lost cycles, saturating at LIMIT, which flags the requester as starved.
module wb_wait_counter #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic starved
);
  logic [3:0] count;
  assign starved = count == 4'(LIMIT);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clr) count <= '0;
    else if (inc && !starved) count <= count + 4'd1;
endmodule

// File: rtl/write_back_arbiter.sv
// write_back_arbiter: shares the register-file write port between MEM, ALU and PC-link results,
// fixed priority MEM > ALU > PC with promotion of starved requesters.
module write_back_arbiter
  import write_back_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REG_ADDR_W = 5,
  parameter int unsigned STARVE_LIMIT = WB_STARVE_LIMIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_stall,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  pc_valid,
  output logic                  pc_ready,
  input  logic [REG_ADDR_W-1:0] pc_rd,
  input  logic [XLEN-1:0]       pc_value,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output write_back_select_t    wb_sel
);
  logic [WB_NUM_SRC-1:0] valid, starved, cand, gnt;
  logic [REG_ADDR_W-1:0] nxt_addr;
  logic [XLEN-1:0] nxt_data;
  write_back_select_t nxt_sel;
  logic upd;
  assign valid = {pc_valid, alu_valid, mem_valid};
  // starved requesters preempt; bit 0 (MEM) is highest priority, lowest set bit wins
  assign cand = (rst_n && !wb_stall) ? (|(starved & valid) ? starved & valid : valid) : '0;
  assign gnt = cand & (~cand + 3'd1);
  assign {pc_ready, alu_ready, mem_ready} = gnt;
  for (genvar i = 0; i < WB_NUM_SRC; i++) begin : g_wait
    wb_wait_counter #(.LIMIT(STARVE_LIMIT)) u_wait (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (valid[i] && !gnt[i]),
      .clr    (!valid[i] || gnt[i]),
      .starved(starved[i])
    );
  end
  always_comb begin
    nxt_addr = gnt[0] ? mem_rd : gnt[1] ? alu_rd : pc_rd;
    nxt_data = gnt[0] ? mem_data : gnt[1] ? alu_data : pc_value + XLEN'(4);
    nxt_sel  = gnt[0] ? WRITE_BACK_SEL_MEM : gnt[1] ? WRITE_BACK_SEL_ALU : WRITE_BACK_SEL_PC;
    upd      = |gnt && nxt_addr != '0;
  end
  // x0 writes are accepted but leave the output register untouched
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      wb_sel   <= WRITE_BACK_SEL_ALU;
    end else begin
      rf_we <= upd;
      if (upd) begin
        rf_waddr <= nxt_addr;
        rf_wdata <= nxt_data;
        wb_sel   <= nxt_sel;
      end
    end
endmodule

// File: doc/write_back_arbiter.md
Name: write_back_arbiter

Overview:
Shares the single register-file write port between three write-back requesters: load return (MEM), ALU result and jump link (PC).
- Arbitrates with fixed priority plus starvation promotion.
- Registers the winning write and drives the write_back_select_t code of the registered source.
- Sits between the execute/memory stages and the register file.
- Replaces static per-instruction write-back selection once loads complete with variable latency.

Parameters:
XLEN, 32, data width of arch_reg.
REG_ADDR_W, 5, register index width.
STARVE_LIMIT, 4, consecutive lost cycles before a requester is promoted (legal range 1..15).

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
wb_stall  input  1  pipeline hold; no grants while high
mem_valid  input  1  load result available
mem_ready  output  1  load result accepted this cycle
mem_rd  input  REG_ADDR_W  load destination
mem_data  input  XLEN  load data
alu_valid / alu_ready / alu_rd / alu_data  same as mem_*, for the ALU result
pc_valid / pc_ready / pc_rd  same as mem_*, for the link write
pc_value  input  XLEN  PC of the jump instruction
rf_we  output  1  register-file write enable
rf_waddr  output  REG_ADDR_W  write index
rf_wdata  output  XLEN  write data
wb_sel  output  2  write_back_select_t of the registered write

Behaviour:
Clock and reset:
- One clock, clk.
- Reset rst_n is asynchronous and active-low.
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, wb_sel=WRITE_BACK_SEL_ALU, all wait counters=0.
- While rst_n=0, all *_ready outputs are 0.

Handshake:
- valid/ready per requester. A transfer occurs when valid & ready are both high at a rising edge.
- The requester holds valid, rd and data stable until the transfer occurs.
- ready is combinational from the valids, wb_stall and the counters; at most one ready is high per cycle.
- No grant when wb_stall=1 or no valid is high.

Arbitration:
- Base priority order: MEM > ALU > PC.
- Each requester has a wait counter, width 4, saturating at STARVE_LIMIT.
- Counter update per cycle: +1 if valid and not granted (wb_stall cycles included); cleared when granted or when valid is low.
- A requester whose counter equals STARVE_LIMIT is "starved".
- If any requester is starved, grant goes to the highest base-priority starved requester; otherwise to the highest base-priority valid requester.

Output register (1-cycle latency from transfer edge):
- MEM grant: rf_waddr=mem_rd, rf_wdata=mem_data, wb_sel=WRITE_BACK_SEL_MEM.
- ALU grant: rf_waddr=alu_rd, rf_wdata=alu_data, wb_sel=WRITE_BACK_SEL_ALU.
- PC grant: rf_waddr=pc_rd, rf_wdata=pc_value+4 truncated to XLEN (wraps 0xFFFFFFFC -> 0x00000000), wb_sel=WRITE_BACK_SEL_PC.
- rf_we = 1 only when a transfer occurred and the index is nonzero. A write to x0 is accepted (ready high) but rf_we stays 0.
- No transfer: rf_we=0; rf_waddr, rf_wdata and wb_sel hold their previous values.
- wb_sel never takes WRITE_BACK_SEL_RSVD.

Boundary conditions:
- All three valid every cycle: the maximum wait for any requester is bounded by 2*STARVE_LIMIT+2 cycles.
- Stall deasserts while counters are saturated: starved requesters win in base order on the first free cycle.
- Reset mid-operation: the registered write is dropped immediately (rf_we=0 asynchronously). Requesters must re-present after reset.

Decomposition:
- write_back_pkg already holds write_back_select_t; the arbiter reuses it as the source ID.
- Add to write_back_pkg:
  - WB_NUM_SRC=3
  - WB_STARVE_LIMIT_DEFAULT=4
  - a packed wb_req_t struct {valid, rd, data}
- One sub-module: wb_wait_counter (saturating counter with inc/clr inputs and a starved output), instanced once per requester.

Test Plan:
1. Single ALU request, rd=5, data=0x12345678 -> alu_ready same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0x12345678, wb_sel=ALU.
2. MEM and ALU valid together (rd 3/4) -> MEM granted first, then ALU next cycle; rf_waddr sequence 3,4; wb_sel MEM,ALU.
3. PC request with pc_value=0xFFFFFFFC, rd=1 -> rf_wdata=0x00000000, wb_sel=PC. Then rd=0 -> pc_ready=1, rf_we=0, rf_waddr/rf_wdata hold.
4. STARVE_LIMIT=4, MEM and PC continuously valid (MEM re-presents a new value each cycle) -> PC granted on exactly the 5th cycle after it first asserts; PC counter cleared.
5. wb_stall=1 for 6 cycles with all valid -> no ready, rf_we=0. On release, MEM granted first (all starved, base order), then ALU, then PC.
6. Assert rst_n=0 between clock edges while rf_we=1 -> rf_we, rf_waddr and rf_wdata go to 0 before the next edge; readies 0 throughout reset.
